// File: rtl/wb_regfile_2023211063_pkg.sv
// Shared widths, reset value, debug FSM encodings and read-bypass helper for the WB register file.
// Debug access port support is enabled by defining REGFILE_DBG_PORT_EN.
package wb_regfile_2023211063_pkg;

    localparam int unsigned RegNum   = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned RegW     = 32;

    typedef logic [RegAddrW-1:0] reg_addr_t;
    typedef logic [RegW-1:0]     reg_data_t;

    localparam reg_data_t ZeroWord = '0;

    localparam logic [1:0] DBG_IDLE = 2'd0;
    localparam logic [1:0] DBG_WAIT = 2'd1;
    localparam logic [1:0] DBG_ACK  = 2'd2;

    // x0 reads as zero; a same-cycle WB write to the addressed register is forwarded.
    function automatic reg_data_t rd_bypass(input reg_addr_t raddr, input logic we,
                                            input reg_addr_t waddr, input reg_data_t wdata,
                                            input reg_data_t stored);
        if (raddr == '0)
            return ZeroWord;
        else if (we && (waddr == raddr))
            return wdata;
        else
            return stored;
    endfunction

endpackage

// File: rtl/wb_regfile_2023211063_if.sv
// WB write / ID read bus of the register file; debug signals exist only with REGFILE_DBG_PORT_EN.
interface wb_regfile_2023211063_if;
    import wb_regfile_2023211063_pkg::*;

    logic      we_i;
    reg_addr_t waddr_i;
    reg_data_t wdata_i;
    reg_addr_t raddr1_i;
    reg_data_t rdata1_o;
    reg_addr_t raddr2_i;
    reg_data_t rdata2_o;
`ifdef REGFILE_DBG_PORT_EN
    logic      dbg_req_i;
    logic      dbg_we_i;
    reg_addr_t dbg_addr_i;
    reg_data_t dbg_wdata_i;
    reg_data_t dbg_rdata_o;
    logic      dbg_ack_o;
`endif

    modport master (
        output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
        input  rdata1_o, rdata2_o
`ifdef REGFILE_DBG_PORT_EN
        , output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i
        , input  dbg_rdata_o, dbg_ack_o
`endif
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
        output rdata1_o, rdata2_o
`ifdef REGFILE_DBG_PORT_EN
        , input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i
        , output dbg_rdata_o, dbg_ack_o
`endif
    );

endinterface

// File: rtl/wb_regfile_2023211063_dbg_arb.sv
// Debug access FSM and write-port mux; without REGFILE_DBG_PORT_EN it passes the WB write straight through.
module regfile_dbg_arb_2023211063
    import wb_regfile_2023211063_pkg::*;
(
`ifdef REGFILE_DBG_PORT_EN
    input  logic      clk,
    input  logic      rst,
    input  logic      dbg_req,
    input  logic      dbg_we,
    input  reg_addr_t dbg_addr,
    input  reg_data_t dbg_wdata,
    input  reg_data_t dbg_rd_val,
    output reg_data_t dbg_rdata,
    output logic      dbg_ack,
`endif
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
    output logic      wr_en,
    output reg_addr_t wr_addr,
    output reg_data_t wr_data
);

`ifdef REGFILE_DBG_PORT_EN
    logic [1:0] state;
    logic       dbg_wr;

    // WB always owns the write port; a debug write only lands in a WAIT cycle with we idle.
    always_comb begin
        dbg_wr  = (state == DBG_WAIT) && dbg_we && !we;
        wr_en   = we || dbg_wr;
        wr_addr = we ? waddr : dbg_addr;
        wr_data = we ? wdata : dbg_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DBG_IDLE;
            dbg_rdata <= '0;
            dbg_ack   <= 1'b0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                DBG_IDLE: if (dbg_req) state <= DBG_WAIT;
                DBG_WAIT: begin
                    if (!dbg_we) begin
                        dbg_rdata <= dbg_rd_val;
                        state     <= DBG_ACK;
                        dbg_ack   <= 1'b1;
                    end else if (!we) begin
                        state   <= DBG_ACK;
                        dbg_ack <= 1'b1;
                    end
                end
                DBG_ACK:  state <= DBG_IDLE;
                default:  state <= DBG_IDLE;
            endcase
        end
    end
`else
    always_comb begin
        wr_en   = we;
        wr_addr = waddr;
        wr_data = wdata;
    end
`endif

endmodule

// File: rtl/wb_regfile_2023211063.sv
// Write-back register file: one write port, two bypassed combinational read ports.
// Optional debug access port selected by REGFILE_DBG_PORT_EN.
module wb_regfile_2023211063
    import wb_regfile_2023211063_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    wb_regfile_2023211063_if.slave   bus
);

    reg_data_t regs [RegNum];
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        bus.rdata1_o = rd_bypass(bus.raddr1_i, bus.we_i, bus.waddr_i, bus.wdata_i, regs[bus.raddr1_i]);
        bus.rdata2_o = rd_bypass(bus.raddr2_i, bus.we_i, bus.waddr_i, bus.wdata_i, regs[bus.raddr2_i]);
    end

`ifdef REGFILE_DBG_PORT_EN
    reg_data_t dbg_rd_val;

    always_comb begin
        dbg_rd_val = rd_bypass(bus.dbg_addr_i, bus.we_i, bus.waddr_i, bus.wdata_i, regs[bus.dbg_addr_i]);
    end
`endif

    regfile_dbg_arb_2023211063 u_arb (
`ifdef REGFILE_DBG_PORT_EN
        .clk        (clk),
        .rst        (rst),
        .dbg_req    (bus.dbg_req_i),
        .dbg_we     (bus.dbg_we_i),
        .dbg_addr   (bus.dbg_addr_i),
        .dbg_wdata  (bus.dbg_wdata_i),
        .dbg_rd_val (dbg_rd_val),
        .dbg_rdata  (bus.dbg_rdata_o),
        .dbg_ack    (bus.dbg_ack_o),
`endif
        .we         (bus.we_i),
        .waddr      (bus.waddr_i),
        .wdata      (bus.wdata_i),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

endmodule
